// File: rtl/stage_mem_wb_lsu.sv
// MEM/WB stage: load formatting, memory wait-state handling and registered write-back.
// A load that misses dm_rvalid parks its fields in WAIT until the data arrives.
module stage_mem_wb_lsu #(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN/8)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_mem_rd,
  input  logic [2:0]      ex_funct3,
  input  logic [OFFW-1:0] ex_offset,
  input  logic [4:0]      ex_rd_idx,
  input  logic [XLEN-1:0] ex_rd_data,
  input  logic            dm_rvalid,
  input  logic [XLEN-1:0] dm_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_idx,
  output logic [XLEN-1:0] wb_data,
  output logic            ld_err,
  output logic [31:0]     stall_cnt
);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [2:0]      f3;
    logic [OFFW-1:0] off;
    logic [4:0]      idx;
  } ld_t;

  state_t          state_q, state_d;
  ld_t             ld_q, ld_d;
  logic            v_d, we_d, err_d;
  logic [4:0]      idx_d;
  logic [XLEN-1:0] data_d;

  function automatic logic ld_bad(
    input logic [2:0]      f3,
    input logic [OFFW-1:0] off
  );
    logic bad;
    bad = 1'b0;
    unique case (f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = off[0];
      3'b010:         bad = |off[1:0];
      3'b110:         bad = (XLEN == 32) || (|off[1:0]);
      3'b011:         bad = (XLEN == 32) || (|off);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Shift the addressed bytes down, then mask and fill the upper bits.
  function automatic logic [XLEN-1:0] ld_fmt(
    input logic [2:0]      f3,
    input logic [OFFW-1:0] off,
    input logic [XLEN-1:0] rdata
  );
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] m;
    logic            s;
    sh = rdata >> {off, 3'b000};
    m  = '1;
    s  = 1'b0;
    unique case (f3[1:0])
      2'b00: begin
        m = XLEN'(8'hFF);
        s = sh[7];
      end
      2'b01: begin
        m = XLEN'(16'hFFFF);
        s = sh[15];
      end
      2'b10: begin
        m = XLEN'(32'hFFFF_FFFF);
        s = sh[31];
      end
      default: begin
        m = '1;
        s = 1'b0;
      end
    endcase
    if (f3[2]) s = 1'b0;
    return (sh & m) | ({XLEN{s}} & ~m);
  endfunction

  assign ex_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    v_d     = 1'b0;
    err_d   = 1'b0;
    we_d    = wb_we;
    idx_d   = wb_idx;
    data_d  = wb_data;
    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!ex_mem_rd) begin
            v_d    = 1'b1;
            we_d   = (ex_rd_idx != 5'd0);
            idx_d  = ex_rd_idx;
            data_d = ex_rd_data;
          end else if (ld_bad(ex_funct3, ex_offset)) begin
            v_d    = 1'b1;
            err_d  = 1'b1;
            we_d   = 1'b0;
            idx_d  = ex_rd_idx;
            data_d = '0;
          end else if (dm_rvalid) begin
            v_d    = 1'b1;
            we_d   = (ex_rd_idx != 5'd0);
            idx_d  = ex_rd_idx;
            data_d = ld_fmt(ex_funct3, ex_offset, dm_rdata);
          end else begin
            ld_d.f3  = ex_funct3;
            ld_d.off = ex_offset;
            ld_d.idx = ex_rd_idx;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (dm_rvalid) begin
          v_d     = 1'b1;
          we_d    = (ld_q.idx != 5'd0);
          idx_d   = ld_q.idx;
          data_d  = ld_fmt(ld_q.f3, ld_q.off, dm_rdata);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ld_q      <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_idx    <= '0;
      wb_data   <= '0;
      ld_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state_q  <= state_d;
      ld_q     <= ld_d;
      wb_valid <= v_d;
      wb_we    <= we_d;
      wb_idx   <= idx_d;
      wb_data  <= data_d;
      ld_err   <= err_d;
      if (state_q == WAIT && !(&stall_cnt))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_stage_mem_wb_lsu.sv
// Bench for stage_mem_wb_lsu at XLEN 32 and 64 against a
// transaction-level model of expected write-backs.
module tb_stage_mem_wb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  t_valid;
  logic        t_mem_rd;
  logic [2:0]  t_f3;
  logic [2:0]  t_off;
  logic [4:0]  t_idx;
  logic [63:0] t_alu;
  logic        dm_rvalid;
  logic [63:0] dm_rdata;

  logic        rdy [2];
  logic        wbv [2];
  logic        wbwe [2];
  logic [4:0]  wbidx [2];
  logic        err [2];
  logic [31:0] sc [2];
  logic [31:0] wbd32;
  logic [63:0] wbd64;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    int          nw;
    logic        err;
    logic        we;
    logic [4:0]  idx;
    logic [63:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic        last_we [2];
  logic [4:0]  last_idx [2];
  logic [63:0] last_data [2];
  int          stall_exp [2];
  int          blo [2];
  int          bhi [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stage_mem_wb_lsu #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(t_valid[0]), .ex_ready(rdy[0]),
    .ex_mem_rd(t_mem_rd), .ex_funct3(t_f3),
    .ex_offset(t_off[1:0]), .ex_rd_idx(t_idx),
    .ex_rd_data(t_alu[31:0]),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata[31:0]),
    .wb_valid(wbv[0]), .wb_we(wbwe[0]),
    .wb_idx(wbidx[0]), .wb_data(wbd32),
    .ld_err(err[0]), .stall_cnt(sc[0])
  );

  stage_mem_wb_lsu #(.XLEN(64)) u64 (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(t_valid[1]), .ex_ready(rdy[1]),
    .ex_mem_rd(t_mem_rd), .ex_funct3(t_f3),
    .ex_offset(t_off), .ex_rd_idx(t_idx),
    .ex_rd_data(t_alu),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .wb_valid(wbv[1]), .wb_we(wbwe[1]),
    .wb_idx(wbidx[1]), .wb_data(wbd64),
    .ld_err(err[1]), .stall_cnt(sc[1])
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic merr(input int xl, input logic [2:0] f3,
                                input logic [2:0] off);
    int sz;
    sz = 1 << f3[1:0];
    if (f3 == 3'b111) return 1'b1;
    if (xl == 32 && (f3 == 3'b011 || f3 == 3'b110)) return 1'b1;
    return (int'(off) % sz) != 0;
  endfunction

  function automatic logic [63:0] mfmt(input int xl, input logic [2:0] f3,
                                       input logic [2:0] off,
                                       input logic [63:0] rd);
    logic [63:0] v, m;
    int sz;
    sz = 1 << f3[1:0];
    v = rd >> (8 * int'(off));
    m = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    v = v & m;
    if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~m;
    if (xl == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int s = 0; s < 2; s++) begin
      last_we[s] = 1'b0;
      last_idx[s] = '0;
      last_data[s] = '0;
      stall_exp[s] = 0;
      blo[s] = 1;
      bhi[s] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        exp_t e;
        logic has;
        logic er;
        logic [63:0] d;
        has = 1'b0;
        er = 1'b0;
        if (s == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin
          e = q0.pop_front();
          has = 1'b1;
        end
        if (s == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin
          e = q1.pop_front();
          has = 1'b1;
        end
        if (has) begin
          last_we[s] = e.we;
          last_idx[s] = e.idx;
          last_data[s] = e.data;
          stall_exp[s] += e.nw;
          er = e.err;
        end
        d = (s == 0) ? {32'h0, wbd32} : wbd64;
        chk($sformatf("wb_valid[%0d]", s), 64'(wbv[s]), 64'(has));
        chk($sformatf("ld_err[%0d]", s), 64'(err[s]), 64'(er));
        chk($sformatf("wb_we[%0d]", s), 64'(wbwe[s]), 64'(last_we[s]));
        chk($sformatf("wb_idx[%0d]", s), 64'(wbidx[s]), 64'(last_idx[s]));
        chk($sformatf("wb_data[%0d]", s), d, last_data[s]);
        if (cyc >= blo[s] && cyc <= bhi[s]) begin
          chk($sformatf("ex_ready[%0d]", s), 64'(rdy[s]), 64'd0);
        end else begin
          chk($sformatf("ex_ready[%0d]", s), 64'(rdy[s]), 64'd1);
          chk($sformatf("stall_cnt[%0d]", s), 64'(sc[s]), 64'(stall_exp[s]));
        end
      end
    end
  end

  task automatic issue(input int s, input logic mr, input logic [2:0] f3,
                       input logic [2:0] off, input logic [4:0] idx,
                       input logic [63:0] alu, input logic [63:0] rd,
                       input int nw);
    exp_t e;
    int xl;
    logic er;
    int ew;
    xl = (s == 1) ? 64 : 32;
    er = mr && merr(xl, f3, off);
    ew = (mr && !er) ? nw : 0;
    @(posedge clk);
    #1;
    t_valid = '0;
    t_valid[s] = 1'b1;
    t_mem_rd = mr;
    t_f3 = f3;
    t_off = off;
    t_idx = idx;
    t_alu = alu;
    dm_rvalid = (ew == 0);
    dm_rdata = rd;
    e.cyc = cyc + 1 + ew;
    e.nw = ew;
    e.err = er;
    e.idx = idx;
    e.we = !er && (idx != 5'd0);
    if (!mr) e.data = (xl == 32) ? {32'h0, alu[31:0]} : alu;
    else if (er) e.data = '0;
    else e.data = mfmt(xl, f3, off, rd);
    if (s == 0) q0.push_back(e);
    else q1.push_back(e);
    if (ew > 0) begin
      blo[s] = cyc + 1;
      bhi[s] = cyc + ew;
      for (int i = 1; i <= ew; i++) begin
        @(posedge clk);
        #1;
        t_f3 = 3'($urandom);
        t_idx = 5'($urandom);
        t_alu = {$urandom, $urandom};
        dm_rvalid = (i == ew);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      t_valid = '0;
      dm_rvalid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    t_valid = '0;
    t_mem_rd = 1'b0;
    t_f3 = '0;
    t_off = '0;
    t_idx = '0;
    t_alu = '0;
    dm_rvalid = 1'b0;
    dm_rdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_wb_valid", 64'(wbv[s]), 64'd0);
      chk("rst_wb_we", 64'(wbwe[s]), 64'd0);
      chk("rst_wb_idx", 64'(wbidx[s]), 64'd0);
      chk("rst_ld_err", 64'(err[s]), 64'd0);
      chk("rst_stall", 64'(sc[s]), 64'd0);
      chk("rst_ready", 64'(rdy[s]), 64'd1);
    end
    chk("rst_data32", 64'(wbd32), 64'd0);
    chk("rst_data64", wbd64, 64'd0);

    chk("pin_lb", mfmt(32, 3'b000, 3'd3, 64'h80FF_0000), 64'hFFFF_FF80);
    chk("pin_lbu", mfmt(32, 3'b100, 3'd3, 64'h80FF_0000), 64'h0000_0080);
    chk("pin_lhu", mfmt(32, 3'b101, 3'd2, 64'h80FF_0000), 64'h0000_80FF);
    chk("pin_lwu64", mfmt(64, 3'b110, 3'd4, 64'h8000_0001_0000_0000),
        64'h0000_0000_8000_0001);
    chk("pin_lw64", mfmt(64, 3'b010, 3'd4, 64'h8000_0001_0000_0000),
        64'hFFFF_FFFF_8000_0001);
    chk("pin_err_lh1", 64'(merr(32, 3'b001, 3'd1)), 64'd1);
    chk("pin_err_ld32", 64'(merr(32, 3'b011, 3'd0)), 64'd1);
    chk("pin_ok_ld64", 64'(merr(64, 3'b011, 3'd0)), 64'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(0, 0, 3'b000, 3'd0, 5'd5, 64'h1234_5678, 64'h0, 0);
    issue(0, 0, 3'b000, 3'd0, 5'd0, 64'hDEAD_BEEF, 64'h0, 0);
    issue(0, 1, 3'b000, 3'd3, 5'd1, 64'h0, 64'h80FF_0000, 0);
    issue(0, 1, 3'b100, 3'd3, 5'd2, 64'h0, 64'h80FF_0000, 0);
    issue(0, 1, 3'b101, 3'd2, 5'd3, 64'h0, 64'h80FF_0000, 0);
    issue(0, 1, 3'b001, 3'd2, 5'd4, 64'h0, 64'h80FF_0000, 0);
    issue(0, 1, 3'b010, 3'd0, 5'd6, 64'h0, 64'hCAFE_F00D, 3);
    idle(2);
    @(negedge clk);
    chk("stall_after_lw", 64'(sc[0]), 64'd3);
    issue(0, 1, 3'b001, 3'd1, 5'd7, 64'h0, 64'h1111_2222, 4);
    issue(0, 1, 3'b011, 3'd0, 5'd8, 64'h0, 64'h3333_4444, 4);
    issue(0, 1, 3'b111, 3'd0, 5'd9, 64'h0, 64'h3333_4444, 0);
    issue(0, 1, 3'b110, 3'd0, 5'd10, 64'h0, 64'h3333_4444, 2);
    issue(0, 1, 3'b100, 3'd1, 5'd11, 64'h0, 64'h0000_9A00, 1);
    issue(0, 1, 3'b000, 3'd2, 5'd0, 64'h0, 64'h0081_0000, 0);
    idle(3);

    issue(1, 1, 3'b110, 3'd4, 5'd12, 64'h0, 64'h8000_0001_0000_0000, 0);
    issue(1, 1, 3'b010, 3'd4, 5'd13, 64'h0, 64'h8000_0001_0000_0000, 0);
    issue(1, 0, 3'b000, 3'd0, 5'd14, 64'hFEDC_BA98_7654_3210, 64'h0, 0);
    issue(1, 1, 3'b011, 3'd0, 5'd15, 64'h0, 64'h0123_4567_89AB_CDEF, 2);
    issue(1, 1, 3'b011, 3'd4, 5'd16, 64'h0, 64'h0123_4567_89AB_CDEF, 0);
    issue(1, 1, 3'b000, 3'd7, 5'd17, 64'h0, 64'h8100_0000_0000_0000, 0);
    issue(1, 1, 3'b101, 3'd6, 5'd18, 64'h0, 64'hF00D_0000_0000_0000, 1);
    issue(1, 1, 3'b010, 3'd2, 5'd19, 64'h0, 64'h0, 0);
    idle(3);
    @(negedge clk);
    chk("stall64", 64'(sc[1]), 64'd3);

    @(posedge clk);
    #1;
    t_valid = 2'b10;
    t_mem_rd = 1'b1;
    t_f3 = 3'b010;
    t_off = 3'd0;
    t_idx = 5'd9;
    dm_rvalid = 1'b0;
    blo[1] = cyc + 1;
    bhi[1] = cyc + 100;
    @(posedge clk);
    #1;
    t_valid = '0;
    @(negedge clk);
    chk("wait_ready", 64'(rdy[1]), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_ready", 64'(rdy[1]), 64'd1);
    chk("mid_rst_valid", 64'(wbv[1]), 64'd0);
    chk("mid_rst_we", 64'(wbwe[1]), 64'd0);
    chk("mid_rst_idx", 64'(wbidx[1]), 64'd0);
    chk("mid_rst_data", wbd64, 64'd0);
    chk("mid_rst_stall", 64'(sc[1]), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dm_rvalid = 1'b1;
    dm_rdata = 64'hAAAA_5555_AAAA_5555;
    idle(4);
    @(negedge clk);
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
